// File: rtl/pc_control.sv
// Program counter with conditional jumps and a LIFO return-address stack.
// Every redirect is registered and appears on PC one rising edge later.
module pc_control #(
  parameter int unsigned STACK_DEPTH = 8
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       stall,
  input  logic [1:0] JCTL,
  input  logic [7:0] addr,
  input  logic       stack_command,
  input  logic [1:0] stack_ctl,
  input  logic       zero_flag,
  output logic [7:0] PC,
  output logic       taken,
  output logic [4:0] stack_depth,
  output logic       stack_empty,
  output logic       stack_full,
  output logic       overflow,
  output logic       underflow
);

  localparam int unsigned AW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
  localparam int unsigned DW = 5;

  logic [7:0]    stack_mem [STACK_DEPTH];
  logic [7:0]    pc_inc;
  logic [7:0]    pc_next;
  logic          taken_next;
  logic [DW-1:0] depth_next;
  logic          overflow_next;
  logic          underflow_next;
  logic          push;

  assign stack_empty = (stack_depth == DW'(0));
  assign stack_full  = (stack_depth == DW'(STACK_DEPTH));
  assign pc_inc      = PC + 8'd1;

  // Next-state selection: stall > stack operation > jump control
  always_comb begin
    pc_next        = PC;
    taken_next     = 1'b0;
    depth_next     = stack_depth;
    overflow_next  = overflow;
    underflow_next = underflow;
    push           = 1'b0;
    if (!stall) begin
      pc_next = pc_inc;
      if (stack_command) begin
        case (stack_ctl)
          2'b01: begin
            if (stack_full) begin
              overflow_next = 1'b1;
            end else begin
              push       = 1'b1;
              depth_next = stack_depth + DW'(1);
              pc_next    = addr;
              taken_next = 1'b1;
            end
          end
          2'b10: begin
            if (stack_empty) begin
              underflow_next = 1'b1;
            end else begin
              depth_next = stack_depth - DW'(1);
              pc_next    = stack_mem[AW'(stack_depth - DW'(1))];
              taken_next = 1'b1;
            end
          end
          default: ;
        endcase
      end else begin
        case (JCTL)
          2'b01: begin
            pc_next    = addr;
            taken_next = 1'b1;
          end
          2'b10: begin
            if (zero_flag) begin
              pc_next    = addr;
              taken_next = 1'b1;
            end
          end
          2'b11: begin
            if (!zero_flag) begin
              pc_next    = addr;
              taken_next = 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      PC          <= 8'h00;
      taken       <= 1'b0;
      stack_depth <= '0;
      overflow    <= 1'b0;
      underflow   <= 1'b0;
    end else begin
      PC          <= pc_next;
      taken       <= taken_next;
      stack_depth <= depth_next;
      overflow    <= overflow_next;
      underflow   <= underflow_next;
    end
  end

  // Stack storage is not reset; entries above stack_depth are never read
  always_ff @(posedge CLK) begin
    if (push && !RST) begin
      stack_mem[AW'(stack_depth)] <= pc_inc;
    end
  end

endmodule
